// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the program-loader encoder.
// The host side drives bundles and consumes words; the encoder side is the slave.
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  Clear;
    logic                  In_Valid;
    logic                  In_Ready;
    logic [2:0]            ImmediateSrc;
    logic [6:0]            Opcode;
    logic [4:0]            Rd;
    logic [4:0]            Rs1;
    logic [4:0]            Rs2;
    logic [2:0]            Funct3;
    logic [6:0]            Funct7;
    logic [31:0]           Immediate;
    logic                  Out_Valid;
    logic                  Out_Ready;
    logic [31:0]           Instr_Out;
    logic [ADDR_WIDTH-1:0] Instr_Addr;
    logic                  Enc_Err;
    logic [1:0]            Err_Code;
    logic [7:0]            Err_Count;

    modport master (
        output Clear, In_Valid, ImmediateSrc, Opcode, Rd, Rs1, Rs2, Funct3, Funct7,
               Immediate, Out_Ready,
        input  In_Ready, Out_Valid, Instr_Out, Instr_Addr, Enc_Err, Err_Code, Err_Count
    );

    modport slave (
        input  Clear, In_Valid, ImmediateSrc, Opcode, Rd, Rs1, Rs2, Funct3, Funct7,
               Immediate, Out_Ready,
        output In_Ready, Out_Valid, Instr_Out, Instr_Addr, Enc_Err, Err_Code, Err_Count
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32IM instruction encoder: packs fields and an immediate into a word (inverse of Imm_Gen),
// range-checks the immediate, stamps a sequential word address and handshakes both sides.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);
    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(4);

    logic                  out_valid_reg;
    logic [31:0]           out_word_reg;
    logic [ADDR_WIDTH-1:0] out_addr_reg;
    logic [ADDR_WIDTH-1:0] next_addr_reg;
    logic                  enc_err_reg;
    logic [1:0]            err_code_reg;
    logic [7:0]            err_count_reg;

    logic [31:0]           imm;
    logic [31:0]           word_next;
    logic [1:0]            chk_code;
    logic                  in_ready;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_base;

    assign imm       = bus.Immediate;
    assign in_ready  = !rst && (!out_valid_reg || bus.Out_Ready);
    assign accept    = bus.In_Valid && in_ready;
    // A coincident Clear restarts numbering at the word being accepted right now.
    assign addr_base = bus.Clear ? BASE_A : next_addr_reg;

    always_comb begin
        word_next = '0;
        case (bus.ImmediateSrc)
            IMM_NONE: word_next = {bus.Funct7, bus.Rs2, bus.Rs1, bus.Funct3, bus.Rd, bus.Opcode};
            IMM_I:    word_next = {imm[11:0], bus.Rs1, bus.Funct3, bus.Rd, bus.Opcode};
            IMM_S:    word_next = {imm[11:5], bus.Rs2, bus.Rs1, bus.Funct3, imm[4:0], bus.Opcode};
            IMM_B:    word_next = {imm[12], imm[10:5], bus.Rs2, bus.Rs1, bus.Funct3,
                                   imm[4:1], imm[11], bus.Opcode};
            IMM_U:    word_next = {imm[31:12], bus.Rd, bus.Opcode};
            IMM_J:    word_next = {imm[20], imm[10:1], imm[11], imm[19:12], bus.Rd, bus.Opcode};
            default:  word_next = '0;
        endcase
    end

    // Priority: bad format code, then misalignment, then range (upper bits must be a sign extension).
    always_comb begin
        chk_code = 2'b00;
        case (bus.ImmediateSrc)
            IMM_I, IMM_S: begin
                if (!((&imm[31:11]) || !(|imm[31:11]))) chk_code = 2'b01;
            end
            IMM_B: begin
                if (imm[0])                                   chk_code = 2'b10;
                else if (!((&imm[31:12]) || !(|imm[31:12]))) chk_code = 2'b01;
            end
            IMM_J: begin
                if (imm[0])                                   chk_code = 2'b10;
                else if (!((&imm[31:20]) || !(|imm[31:20]))) chk_code = 2'b01;
            end
            IMM_U: begin
                if (|imm[11:0]) chk_code = 2'b01;
            end
            IMM_NONE: chk_code = 2'b00;
            default:  chk_code = 2'b11;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_word_reg  <= '0;
            out_addr_reg  <= BASE_A;
            next_addr_reg <= BASE_A;
            enc_err_reg   <= 1'b0;
            err_code_reg  <= 2'b00;
            err_count_reg <= 8'd0;
        end else begin
            enc_err_reg <= 1'b0;
            if (out_valid_reg && bus.Out_Ready) begin
                out_valid_reg <= 1'b0;
            end
            if (bus.Clear) begin
                next_addr_reg <= BASE_A;
                err_count_reg <= 8'd0;
            end
            if (accept) begin
                if (chk_code == 2'b00) begin
                    out_valid_reg <= 1'b1;
                    out_word_reg  <= word_next;
                    out_addr_reg  <= addr_base;
                    next_addr_reg <= addr_base + STEP_A;
                    err_code_reg  <= 2'b00;
                end else begin
                    // Rejected bundles are consumed silently apart from the error report.
                    enc_err_reg  <= 1'b1;
                    err_code_reg <= chk_code;
                    if (bus.Clear) begin
                        err_count_reg <= 8'd1;
                    end else if (err_count_reg != 8'hFF) begin
                        err_count_reg <= err_count_reg + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.In_Ready   = in_ready;
    assign bus.Out_Valid  = out_valid_reg;
    assign bus.Instr_Out  = out_word_reg;
    assign bus.Instr_Addr = out_addr_reg;
    assign bus.Enc_Err    = enc_err_reg;
    assign bus.Err_Code   = err_code_reg;
    assign bus.Err_Count  = err_count_reg;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized round-trip checks of instr_encoder with an 8-bit address space.
module tb_instr_encoder;
    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd5;
    localparam logic [7:0] BASE     = 8'h40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_WIDTH(8)) bus ();

    instr_encoder #(.BASE_ADDR(32'h0000_0040), .ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        bus.ImmediateSrc = src;
        bus.Opcode       = op;
        bus.Rd           = rd;
        bus.Rs1          = rs1;
        bus.Rs2          = rs2;
        bus.Funct3       = f3;
        bus.Funct7       = f7;
        bus.Immediate    = imm;
        bus.In_Valid     = 1'b1;
    endtask

    function automatic logic [31:0] imm_gen(input logic [31:0] w, input logic [2:0] src);
        case (src)
            IMM_I:   return {{20{w[31]}}, w[31:20]};
            IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            IMM_U:   return {w[31:12], 12'b0};
            IMM_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_reset;
        bus.Clear = 1'b0; bus.In_Valid = 1'b0; bus.Out_Ready = 1'b0;
        set_bundle(IMM_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        bus.In_Valid = 1'b0;
        rst = 1'b1;
        tick; tick;
        tests_run++;
        if (bus.In_Ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 0", bus.In_Ready); end
        tests_run++;
        if (bus.Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", bus.Out_Valid); end
        tests_run++;
        if (bus.Instr_Out !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got %h exp 0", bus.Instr_Out); end
        tests_run++;
        if (bus.Instr_Addr !== BASE) begin tests_failed++; $display("FAIL reset_addr got %h exp %h", bus.Instr_Addr, BASE); end
        tests_run++;
        if ({bus.Enc_Err, bus.Err_Code, bus.Err_Count} !== 11'h0) begin
            tests_failed++;
            $display("FAIL reset_err got err=%b code=%b cnt=%0d exp all 0", bus.Enc_Err, bus.Err_Code, bus.Err_Count);
        end
        rst = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_single;
        bus.Out_Ready = 1'b1;
        set_bundle(IMM_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        tick;
        bus.In_Valid = 1'b0;
        $display("[TB] addi x1,x0,-1 -> %h @ %h", bus.Instr_Out, bus.Instr_Addr);
        tests_run++;
        if (bus.Out_Valid !== 1'b1 || bus.Instr_Out !== 32'hFFF0_0093 || bus.Instr_Addr !== BASE) begin
            tests_failed++;
            $display("FAIL addi got v=%b %h @%h exp v=1 fff00093 @%h", bus.Out_Valid, bus.Instr_Out, bus.Instr_Addr, BASE);
        end
        tick;
        tests_run++;
        if (bus.Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL addi_drain got v=%b exp 0", bus.Out_Valid); end
    endtask

    task automatic test_back_to_back;
        bus.Out_Ready = 1'b1;
        set_bundle(IMM_S, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        tick;
        $display("[TB] sw x2,8(x1) -> %h @ %h", bus.Instr_Out, bus.Instr_Addr);
        tests_run++;
        if (bus.Out_Valid !== 1'b1 || bus.Instr_Out !== 32'h0020_A423 || bus.Instr_Addr !== 8'h44) begin
            tests_failed++;
            $display("FAIL sw got v=%b %h @%h exp v=1 0020a423 @44", bus.Out_Valid, bus.Instr_Out, bus.Instr_Addr);
        end
        set_bundle(IMM_B, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC);
        tick;
        $display("[TB] beq x0,x0,-4 -> %h @ %h", bus.Instr_Out, bus.Instr_Addr);
        tests_run++;
        if (bus.Out_Valid !== 1'b1 || bus.Instr_Out !== 32'hFE00_0EE3 || bus.Instr_Addr !== 8'h48) begin
            tests_failed++;
            $display("FAIL beq got v=%b %h @%h exp v=1 fe000ee3 @48", bus.Out_Valid, bus.Instr_Out, bus.Instr_Addr);
        end
        set_bundle(IMM_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        tick;
        bus.In_Valid = 1'b0;
        $display("[TB] lui x5,0x12345 -> %h @ %h", bus.Instr_Out, bus.Instr_Addr);
        tests_run++;
        if (bus.Out_Valid !== 1'b1 || bus.Instr_Out !== 32'h1234_52B7 || bus.Instr_Addr !== 8'h4C) begin
            tests_failed++;
            $display("FAIL lui got v=%b %h @%h exp v=1 123452b7 @4c", bus.Out_Valid, bus.Instr_Out, bus.Instr_Addr);
        end
        tick;
        tests_run++;
        if (bus.Out_Valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got v=%b exp 0", bus.Out_Valid); end
    endtask

    task automatic test_rejects;
        logic [2:0]  srcs [3];
        logic [31:0] imms [3];
        logic [1:0]  codes[3];
        srcs  = '{IMM_I, IMM_B, 3'b111};
        imms  = '{32'd2048, 32'd3, 32'd0};
        codes = '{2'b01, 2'b10, 2'b11};
        bus.Out_Ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_bundle(srcs[k], 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imms[k]);
            tick;
            $display("[TB] reject src=%0d imm=%h -> err=%b code=%b cnt=%0d", srcs[k], imms[k], bus.Enc_Err, bus.Err_Code, bus.Err_Count);
            tests_run++;
            if (bus.Enc_Err !== 1'b1 || bus.Err_Code !== codes[k] || bus.Out_Valid !== 1'b0
                || bus.Err_Count !== 8'(k + 1)) begin
                tests_failed++;
                $display("FAIL reject%0d got err=%b code=%b v=%b cnt=%0d exp err=1 code=%b v=0 cnt=%0d",
                         k, bus.Enc_Err, bus.Err_Code, bus.Out_Valid, bus.Err_Count, codes[k], k + 1);
            end
        end
        bus.In_Valid = 1'b0;
        tick;
        tests_run++;
        if (bus.Enc_Err !== 1'b0 || bus.Err_Code !== 2'b11 || bus.Err_Count !== 8'd3) begin
            tests_failed++;
            $display("FAIL reject_hold got err=%b code=%b cnt=%0d exp err=0 code=11 cnt=3", bus.Enc_Err, bus.Err_Code, bus.Err_Count);
        end
        set_bundle(IMM_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        tick;
        bus.In_Valid = 1'b0;
        $display("[TB] addi x1,x0,-2048 -> %h @ %h", bus.Instr_Out, bus.Instr_Addr);
        tests_run++;
        if (bus.Instr_Out !== 32'h8000_0093 || bus.Instr_Addr !== 8'h50 || bus.Err_Code !== 2'b00) begin
            tests_failed++;
            $display("FAIL after_reject got %h @%h code=%b exp 80000093 @50 code=00", bus.Instr_Out, bus.Instr_Addr, bus.Err_Code);
        end
        tick;
    endtask

    task automatic test_backpressure;
        bus.Out_Ready = 1'b0;
        set_bundle(IMM_I, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick;
        set_bundle(IMM_S, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (bus.In_Ready !== 1'b0 || bus.Out_Valid !== 1'b1 || bus.Instr_Out !== 32'h0050_0193
                || bus.Instr_Addr !== 8'h54) begin
                tests_failed++;
                $display("FAIL stall%0d got rdy=%b v=%b %h @%h exp rdy=0 v=1 00500193 @54",
                         k, bus.In_Ready, bus.Out_Valid, bus.Instr_Out, bus.Instr_Addr);
            end
            tick;
        end
        bus.Out_Ready = 1'b1;
        #1;
        tests_run++;
        if (bus.In_Ready !== 1'b1) begin tests_failed++; $display("FAIL release_ready got %b exp 1", bus.In_Ready); end
        tick;
        bus.In_Valid = 1'b0;
        $display("[TB] backpressure release -> %h @ %h", bus.Instr_Out, bus.Instr_Addr);
        tests_run++;
        if (bus.Out_Valid !== 1'b1 || bus.Instr_Out !== 32'h0020_A423 || bus.Instr_Addr !== 8'h58) begin
            tests_failed++;
            $display("FAIL release_word got v=%b %h @%h exp v=1 0020a423 @58", bus.Out_Valid, bus.Instr_Out, bus.Instr_Addr);
        end
        tick;
    endtask

    task automatic test_clear;
        bus.Out_Ready = 1'b1;
        bus.Clear     = 1'b1;
        set_bundle(IMM_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        tick;
        bus.Clear = 1'b0;
        $display("[TB] clear+addi -> %h @ %h cnt=%0d", bus.Instr_Out, bus.Instr_Addr, bus.Err_Count);
        tests_run++;
        if (bus.Instr_Out !== 32'hFFF0_0093 || bus.Instr_Addr !== BASE || bus.Err_Count !== 8'd0) begin
            tests_failed++;
            $display("FAIL clear_accept got %h @%h cnt=%0d exp fff00093 @40 cnt=0", bus.Instr_Out, bus.Instr_Addr, bus.Err_Count);
        end
        set_bundle(IMM_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        tick;
        bus.In_Valid  = 1'b0;
        bus.Out_Ready = 1'b0;
        tests_run++;
        if (bus.Instr_Addr !== 8'h44) begin tests_failed++; $display("FAIL clear_next got @%h exp @44", bus.Instr_Addr); end
        bus.Clear = 1'b1;
        tick;
        bus.Clear = 1'b0;
        tests_run++;
        if (bus.Out_Valid !== 1'b1 || bus.Instr_Out !== 32'h1234_52B7 || bus.Instr_Addr !== 8'h44) begin
            tests_failed++;
            $display("FAIL clear_hold got v=%b %h @%h exp v=1 123452b7 @44", bus.Out_Valid, bus.Instr_Out, bus.Instr_Addr);
        end
        bus.Out_Ready = 1'b1;
        set_bundle(3'b110, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick;
        bus.Clear = 1'b1;
        tick;
        bus.Clear    = 1'b0;
        bus.In_Valid = 1'b0;
        $display("[TB] clear+reject -> cnt=%0d", bus.Err_Count);
        tests_run++;
        if (bus.Err_Count !== 8'd1 || bus.Enc_Err !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_reject got cnt=%0d err=%b exp cnt=1 err=1", bus.Err_Count, bus.Enc_Err);
        end
        tick;
    endtask

    task automatic test_saturate;
        bus.Out_Ready = 1'b1;
        set_bundle(3'b111, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        for (int k = 0; k < 300; k++) tick;
        bus.In_Valid = 1'b0;
        $display("[TB] 300 rejects -> cnt=%0d", bus.Err_Count);
        tests_run++;
        if (bus.Err_Count !== 8'd255 || bus.Enc_Err !== 1'b1 || bus.Err_Code !== 2'b11) begin
            tests_failed++;
            $display("FAIL saturate got cnt=%0d err=%b code=%b exp 255 1 11", bus.Err_Count, bus.Enc_Err, bus.Err_Code);
        end
        tick;
    endtask

    task automatic test_round_trip;
        logic [7:0]  exp_addr;
        logic [31:0] r, imm, w;
        logic [2:0]  src;
        logic [6:0]  op, f7;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        ok;
        int          bad = 0;
        bus.Out_Ready = 1'b1;
        bus.Clear     = 1'b1;
        tick;
        bus.Clear = 1'b0;
        exp_addr  = BASE;
        for (int i = 0; i < 10000; i++) begin
            r   = $urandom;
            src = 3'($urandom_range(0, 5));
            op  = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            f3  = 3'($urandom); f7 = 7'($urandom);
            case (src)
                IMM_I, IMM_S: imm = {{20{r[11]}}, r[11:0]};
                IMM_B:        imm = {{19{r[12]}}, r[12:1], 1'b0};
                IMM_U:        imm = {r[31:12], 12'b0};
                IMM_J:        imm = {{11{r[20]}}, r[20:1], 1'b0};
                default:      imm = r;
            endcase
            set_bundle(src, op, rd, rs1, rs2, f3, f7, imm);
            tick;
            w  = bus.Instr_Out;
            ok = (bus.Out_Valid === 1'b1) && (bus.Instr_Addr === exp_addr) && (w[6:0] === op);
            if (src != IMM_NONE && imm_gen(w, src) !== imm) ok = 1'b0;
            if (src inside {IMM_I, IMM_U, IMM_J, IMM_NONE} && w[11:7] !== rd) ok = 1'b0;
            if (src inside {IMM_I, IMM_S, IMM_B, IMM_NONE} && (w[19:15] !== rs1 || w[14:12] !== f3)) ok = 1'b0;
            if (src inside {IMM_S, IMM_B, IMM_NONE} && w[24:20] !== rs2) ok = 1'b0;
            if (src == IMM_NONE && w[31:25] !== f7) ok = 1'b0;
            tests_run++;
            if (!ok) begin
                tests_failed++;
                bad++;
                if (bad <= 10)
                    $display("FAIL round_trip%0d src=%0d imm=%h got %h @%h v=%b exp imm_gen=%h @%h",
                             i, src, imm, w, bus.Instr_Addr, bus.Out_Valid, imm, exp_addr);
            end
            exp_addr = exp_addr + 8'd4;
        end
        bus.In_Valid = 1'b0;
        $display("[TB] round trip 10000 bundles, %0d bad", bad);
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_rejects;
        test_backpressure;
        test_clear;
        test_saturate;
        test_round_trip;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes RV32IM instruction fields plus a 32-bit immediate into a 32-bit instruction word. It is the inverse of the immediate generator: for every legal input, feeding the output word back through Imm_Gen with the same ImmediateSrc returns the original Immediate. It sits in the program-loader path between the host/debug link and instruction memory. It range-checks immediates, rejects illegal ones, stamps each emitted word with a sequential word address, and moves data with valid/ready handshakes on both sides.

## Interface
- BASE_ADDR, 32'h0000_0000: address of the first emitted word; bits [1:0] must be 0.
- ADDR_WIDTH, 32: width of Instr_Addr.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Clear  in  1  synchronous clear of the address counter and error count.
- In_Valid  in  1  field bundle valid.
- In_Ready  out  1  block can accept a bundle.
- ImmediateSrc  in  3  format select, `IMM_I/S/B/U/J/NONE` from CPU_Control_Codes.vh.
- Opcode  in  7; Rd, Rs1, Rs2  in  5 each; Funct3  in  3; Funct7  in  7.
- Immediate  in  32  sign-extended byte-offset immediate, same meaning as the Imm_Gen output.
- Out_Valid  out  1  Instr_Out/Instr_Addr valid.
- Out_Ready  in  1  consumer accepts.
- Instr_Out  out  32  encoded instruction.
- Instr_Addr  out  ADDR_WIDTH  word address of Instr_Out.
- Enc_Err  out  1  one-cycle pulse when a bundle is rejected.
- Err_Code  out  2  00 none, 01 immediate out of range, 10 misaligned, 11 invalid ImmediateSrc; held until the next accept.
- Err_Count  out  8  saturating count of rejected bundles.

## Operation
- Accept: In_Valid && In_Ready. In_Ready = !rst && (!Out_Valid || Out_Ready).
- Packing:
  - NONE (R-type): {Funct7,Rs2,Rs1,Funct3,Rd,Opcode}. Immediate is ignored.
  - I: {imm[11:0],Rs1,Funct3,Rd,Opcode}.
  - S: {imm[11:5],Rs2,Rs1,Funct3,imm[4:0],Opcode}.
  - B: {imm[12],imm[10:5],Rs2,Rs1,Funct3,imm[4:1],imm[11],Opcode}.
  - U: {imm[31:12],Rd,Opcode}.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],Rd,Opcode}.
  - Fields unused by a format are ignored.
- Legality checks (first failing check wins, in this order):
  1. ImmediateSrc is not one of the six codes → code 11.
  2. B or J with imm[0]≠0 → code 10.
  3. Range → code 01:
     - I/S: imm[31:11] must be all equal.
     - B: imm[31:12] must be all equal.
     - J: imm[31:20] must be all equal.
     - U: imm[11:0] must be 0.
- Legal accept:
  - Load the output register with the word and Next_Addr; set Out_Valid.
  - Next_Addr += 4, wrapping modulo 2^ADDR_WIDTH.
  - Set Err_Code to 00.
- Illegal accept:
  - The bundle is consumed but not emitted; the output register and Next_Addr are untouched.
  - Enc_Err pulses high and Err_Code is loaded.
  - Err_Count increments and saturates at 255.
- Output handshake (Out_Valid && Out_Ready) clears Out_Valid, unless a legal accept occurs in the same cycle; in that case the register reloads with the new word.
- Clear:
  - Sets Next_Addr to BASE_ADDR and Err_Count to 0.
  - Does not touch a word already held in the output register.
  - If Clear coincides with a legal accept, the accepted word gets BASE_ADDR and Next_Addr becomes BASE_ADDR+4.
  - If Clear coincides with an illegal accept, Err_Count becomes 1.

## Timing
- Reset values:
  - Out_Valid=0, Instr_Out=0, Instr_Addr=BASE_ADDR.
  - Enc_Err=0, Err_Code=00, Err_Count=0.
  - Next_Addr=BASE_ADDR; In_Ready=0 while rst is high.
- Latency: a word accepted at edge N is visible with Out_Valid=1 after edge N. Enc_Err is high for exactly the cycle after edge N.
- Throughput: one bundle per cycle while Out_Ready=1.
- Backpressure:
  - While Out_Valid && !Out_Ready, In_Ready=0.
  - Instr_Out and Instr_Addr hold stable until the handshake.
- Input fields are sampled only on an accept.
- rst mid-transfer discards the held word and all counters.
- Enc_Err, Err_Code and Err_Count are registered outputs; Out_Valid is registered.

## Test plan
- addi x1,x0,-1 (IMM_I, Opcode 0010011, Rd 1, Funct3 0, Imm 32'hFFFFFFFF), Out_Ready=1 → Instr_Out=32'hFFF00093, Instr_Addr=BASE_ADDR.
- Back-to-back bundles:
  - sw x2,8(x1) (IMM_S, Opcode 0100011, Funct3 010, Rs1 1, Rs2 2, Imm 8) → 32'h0020A423, Instr_Addr=BASE_ADDR+4.
  - beq x0,x0,-4 (IMM_B, Opcode 1100011, Imm 32'hFFFFFFFC) → 32'hFE000EE3, Instr_Addr=BASE_ADDR+8.
  - lui x5,0x12345 (IMM_U, Opcode 0110111, Imm 32'h12345000) → 32'h123452B7.
- Rejects, each with no Out_Valid, Next_Addr unchanged and Err_Count +1:
  - IMM_I with Imm=2048 → Enc_Err pulse, Err_Code=01.
  - IMM_B with Imm=3 → Err_Code=10.
  - ImmediateSrc=3'b111 → Err_Code=11.
- Out_Ready=0 for 5 cycles with In_Valid=1 → In_Ready=0, Instr_Out stable. Out_Ready=1 → the held word is taken, and the next bundle is accepted in the same cycle.
- Clear coincident with a legal accept → Instr_Addr=BASE_ADDR, the next word gets BASE_ADDR+4, Err_Count=0. 300 illegal bundles → Err_Count=255.
- Round-trip: 10k random legal bundles across all formats → Imm_Gen(Instr_Out, ImmediateSrc)==Immediate, register fields match, and addresses increment by 4 with wrap at ADDR_WIDTH=8.
